// File: rtl/ama_riscv_dmem_responder.sv
// ama_riscv_dmem_responder: turns core load/store requests into a ready/valid bus access and aligns load data.
module ama_riscv_dmem_responder (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_en,
    input  logic [3:0]  req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        stall_core,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        access_err,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_we,
    output logic [31:0] bus_wdata,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_data
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;
    state_t state;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic        accept, bad;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    always_comb begin
        accept = (state == IDLE || state == DONE) && req_en;
        bad = (req_funct3[1:0] == 2'b01 && req_addr[1:0] == 2'b11) ||
              (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) ||
              (req_we == 4'b0 && (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11));
        stall_core = accept || state == REQ || state == WAIT_RSP;
        bus_req_valid = state == REQ;
        bus_addr = {addr_q[31:2], 2'b00};
        byte_sel = 8'(bus_rsp_data >> {addr_q[1:0], 3'b000});
        half_sel = addr_q[1] ? bus_rsp_data[31:16] : bus_rsp_data[15:0];
        load_data = funct3_q[1] ? bus_rsp_data :
                    funct3_q[0] ? {{16{~funct3_q[2] & half_sel[15]}}, half_sel} :
                                  {{24{~funct3_q[2] & byte_sel[7]}}, byte_sel};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            funct3_q   <= '0;
            bus_we     <= '0;
            bus_wdata  <= '0;
            rsp_valid  <= 1'b0;
            access_err <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            rsp_valid  <= 1'b0;
            access_err <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept && bad) begin
                        access_err <= 1'b1;
                        state      <= DONE;
                    end else if (accept) begin
                        addr_q    <= req_addr;
                        funct3_q  <= req_funct3;
                        bus_we    <= req_we;
                        bus_wdata <= req_wdata;
                        state     <= REQ;
                    end else begin
                        state <= IDLE;
                    end
                end
                REQ: begin
                    // a load may see its data in the same cycle the request is accepted
                    if (bus_req_ready && bus_we != 4'b0) begin
                        state <= DONE;
                    end else if (bus_req_ready && bus_rsp_valid) begin
                        rsp_rdata <= load_data;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end else if (bus_req_ready) begin
                        state <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (bus_rsp_valid) begin
                        rsp_rdata <= load_data;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ama_riscv_dmem_responder.sv
// tb_ama_riscv_dmem_responder: directed and randomized transactions checked against a transaction-level model.
module tb_ama_riscv_dmem_responder;
    logic        clk = 0, rst = 1;
    logic        req_en = 0;
    logic [3:0]  req_we = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [2:0]  req_funct3 = 0;
    logic        stall_core, rsp_valid, access_err, bus_req_valid;
    logic [31:0] rsp_rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_we;
    logic        bus_req_ready = 0, bus_rsp_valid = 0;
    logic [31:0] bus_rsp_data = 0;
    int checks = 0, errors = 0;
    logic [31:0] last_rdata = 0;

    ama_riscv_dmem_responder dut (
        .clk(clk), .rst(rst), .req_en(req_en), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_funct3(req_funct3), .stall_core(stall_core),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .access_err(access_err),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_addr(bus_addr),
        .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_rsp_valid(bus_rsp_valid),
        .bus_rsp_data(bus_rsp_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
        int unsigned b = (w >> (8 * off)) & 32'hff;
        int unsigned h = (w >> (16 * (off / 2))) & 32'hffff;
        case (f3)
            3'b000: return b >= 128 ? b - 256 : b;
            3'b001: return h >= 32768 ? h - 65536 : h;
            3'b100: return b;
            3'b101: return h;
            default: return w;
        endcase
    endfunction

    task automatic scramble();
        req_en = 1'($urandom);
        req_we = 4'($urandom);
        req_addr = $urandom;
        req_wdata = $urandom;
        req_funct3 = 3'($urandom);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Starts between edges (after a negedge) and returns in the DONE cycle with req_en low.
    task automatic xact(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, input int rdly, input int sdly, input logic [31:0] word);
        logic load, err;
        load = we == 4'b0;
        err = (f3[1:0] == 2'b01 && addr[1:0] == 2'd3) || (f3[1:0] == 2'b10 && addr[1:0] != 2'd0) ||
              (load && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7));
        req_en = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
        #1 check("stall_on_request", stall_core, 1);
        next_cycle();
        if (!err) begin
            for (int i = 0; i <= rdly; i++) begin
                scramble();
                bus_req_ready = i == rdly;
                bus_rsp_valid = (i == rdly && load && sdly == 0) || (i < rdly && $urandom_range(1) == 1);
                bus_rsp_data = (i == rdly) ? word : $urandom;
                #1;
                check("req_valid", bus_req_valid, 1);
                check("req_addr", bus_addr, {addr[31:2], 2'b00});
                check("req_we", bus_we, we);
                check("req_wdata", bus_wdata, wdata);
                check("req_stall", stall_core, 1);
                check("req_no_rsp", rsp_valid, 0);
                next_cycle();
            end
            bus_req_ready = 0;
            bus_rsp_valid = 0;
            if (load)
                for (int i = 1; i <= sdly; i++) begin
                    scramble();
                    bus_rsp_valid = i == sdly;
                    bus_rsp_data = (i == sdly) ? word : $urandom;
                    #1;
                    check("wait_no_req", bus_req_valid, 0);
                    check("wait_stall", stall_core, 1);
                    check("wait_no_rsp", rsp_valid, 0);
                    next_cycle();
                end
        end
        req_en = 0;
        bus_req_ready = 1'($urandom);
        bus_rsp_valid = 1'($urandom);
        bus_rsp_data = $urandom;
        if (load && !err) last_rdata = exp_load(f3, addr[1:0], word);
        #1;
        check("done_rsp_valid", rsp_valid, load && !err);
        check("done_access_err", access_err, err);
        check("done_no_req", bus_req_valid, 0);
        check("done_stall", stall_core, 0);
        check("done_rdata", rsp_rdata, last_rdata);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        #1;
        check("idle_stall", stall_core, 0);
        check("idle_no_req", bus_req_valid, 0);
        check("idle_no_rsp", rsp_valid, 0);
        check("idle_no_err", access_err, 0);
        check("idle_rdata_hold", rsp_rdata, last_rdata);
    endtask

    initial begin
        #1;
        check("rst_stall", stall_core, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_access_err", access_err, 0);
        check("rst_req_valid", bus_req_valid, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_we", bus_we, 0);
        @(negedge clk);
        rst = 0;
        idle_cycle();
        xact(4'b1100, 32'h102, 32'hBEEF0000, 3'b001, 0, 0, 0);
        idle_cycle();
        xact(4'b0000, 32'h203, 0, 3'b000, 0, 1, 32'h80FF1234);
        check("lb_value", rsp_rdata, 32'hFFFFFF80);
        idle_cycle();
        xact(4'b0000, 32'h203, 0, 3'b100, 0, 0, 32'h80FF1234);
        check("lbu_value", rsp_rdata, 32'h00000080);
        idle_cycle();
        xact(4'b0000, 32'h3, 0, 3'b001, 0, 0, 0);
        check("lh_misaligned_keeps_rdata", rsp_rdata, 32'h00000080);
        idle_cycle();
        xact(4'b0000, 32'h300, 0, 3'b010, 5, 3, 32'hCAFEF00D);
        check("lw_value", rsp_rdata, 32'hCAFEF00D);
        xact(4'b0000, 32'h402, 0, 3'b101, 0, 1, 32'h8001ABCD);
        check("lhu_back_to_back", rsp_rdata, 32'h00008001);
        xact(4'b0011, 32'h500, 32'h00001234, 3'b001, 1, 0, 0);
        idle_cycle();
        for (int n = 0; n < 300; n++) begin
            xact($urandom_range(1) == 1 ? 4'b0 : 4'($urandom_range(15, 1)), $urandom, $urandom,
                 3'($urandom), $urandom_range(3), $urandom_range(3), $urandom);
            if ($urandom_range(1) == 1) idle_cycle();
        end
        idle_cycle();
        req_en = 1; req_we = 0; req_addr = 32'h40; req_funct3 = 3'b010;
        next_cycle();
        req_en = 0; bus_req_ready = 1; bus_rsp_valid = 0;
        next_cycle();
        bus_req_ready = 0;
        #1 check("pre_rst_wait_stall", stall_core, 1);
        rst = 1;
        #1;
        check("async_rst_stall", stall_core, 0);
        check("async_rst_req", bus_req_valid, 0);
        check("async_rst_rdata", rsp_rdata, 0);
        check("async_rst_rsp", rsp_valid, 0);
        @(negedge clk);
        rst = 0;
        bus_rsp_valid = 1;
        bus_rsp_data = 32'h12345678;
        @(negedge clk);
        bus_rsp_valid = 0;
        last_rdata = 0;
        #1;
        check("late_rsp_ignored", rsp_valid, 0);
        idle_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
